// File: rtl/instruction_encoder_loader.sv
// -----------------------------------------------------------------------------
// instruction_encoder_loader
//
// Purpose:
//   Packs instruction fields into 8-bit instruction words and writes them one
//   after another into the instruction memory. It is used to load a program
//   before the processor starts running.
//     register form : word = {op_code[2:0], rs[1:0], low3[2:0]}
//     immediate form: word = {op_code[2:0], imm5[4:0]}
//   A load session begins with `start` and ends after a beat flagged
//   `in_last`, or when the memory is full.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   When defined, `checksum` is the XOR of every word written in the current
//   or most recent session. When undefined, `checksum` is tied to 0 and no
//   accumulator register is built.
//
// Handshake:
//   The input side uses valid/ready. A field set is accepted on a rising edge
//   where in_valid && in_ready. in_valid may be raised at any time. Fields must
//   stay stable while in_valid is high and in_ready is low. in_ready is high
//   only in LOAD and only while the memory is not full.
//
// Ports:
//   clock, reset_n     rising-edge clock; asynchronous active-low reset
//   start              one-cycle session request (honoured in IDLE only)
//   in_valid/in_ready  field-set handshake
//   in_last            marks the final field set of the program
//   op_code, rs, low3, use_imm5, imm5   instruction fields
//   mem_we, mem_addr, mem_wdata         instruction memory write port
//   count              words accepted in the current or last session
//   full               count == DEPTH
//   busy               state is not IDLE
//   done               one-cycle pulse at session end
//   checksum           XOR of the session's written words (see above)
//   dbg_state          current FSM state (0 IDLE, 1 LOAD, 2 DONE)
// -----------------------------------------------------------------------------
module instruction_encoder_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        op_code,
   input  logic [1:0]        rs,
   input  logic [2:0]        low3,
   input  logic              use_imm5,
   input  logic [4:0]        imm5,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              busy,
   output logic              done,
   output logic [7:0]        checksum,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t            r_state;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [7:0]        r_mem_wdata;
   logic [ADDR_W:0]   r_count;

   logic              w_full;
   logic              w_in_ready;
   logic              w_accept;
   logic [7:0]        w_word;
   logic [ADDR_W:0]   w_count_inc;

   assign w_full      = (r_count == DEPTH_C);
   assign w_in_ready  = (r_state == ST_LOAD) && !w_full;
   assign w_accept    = in_valid && w_in_ready;
   assign w_count_inc = r_count + 1'b1;

   // The unused fields of the chosen form are ignored.
   assign w_word = use_imm5 ? {op_code, imm5} : {op_code, rs, low3};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 8'h00;
         r_count     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_mem_we <= 1'b0;
               if (start) begin
                  r_count <= '0;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               // The write stage only pulses on an accept. Address and data
               // keep their last values.
               r_mem_we <= w_accept;
               if (w_accept) begin
                  r_mem_addr  <= r_count[ADDR_W-1:0];
                  r_mem_wdata <= w_word;
                  r_count     <= w_count_inc;
                  // Leave on the last beat, or when this beat fills the
                  // memory. This is what prevents a write past DEPTH-1.
                  if (in_last || (w_count_inc == DEPTH_C))
                     r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // The final write is visible in this cycle, alongside done.
               r_mem_we <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_mem_we <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] r_checksum;

   // A word is accumulated in the cycle it is actually written.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_checksum <= 8'h00;
      else if ((r_state == ST_IDLE) && start)
         r_checksum <= 8'h00;
      else if (r_mem_we)
         r_checksum <= r_checksum ^ r_mem_wdata;
   end

   assign checksum = r_checksum;
`else
   assign checksum = 8'h00;
`endif

   assign in_ready  = w_in_ready;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign count     = r_count;
   assign full      = w_full;
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_encoder_loader
//
// Directed bench for instruction_encoder_loader (DEPTH=32). Inputs change 1ns
// after a rising edge, and outputs are sampled at that same point. All expected
// words were computed by hand from the packing formulas.
// -----------------------------------------------------------------------------
module tb_instruction_encoder_loader;

   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUT signals ----------------
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_last = 1'b0;
   logic [2:0]        op_code = 3'd0;
   logic [1:0]        rs = 2'd0;
   logic [2:0]        low3 = 3'd0;
   logic              use_imm5 = 1'b0;
   logic [4:0]        imm5 = 5'd0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              busy;
   logic              done;
   logic [7:0]        checksum;
   logic [1:0]        dbg_state;

   instruction_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_last  (in_last),
      .op_code  (op_code),
      .rs       (rs),
      .low3     (low3),
      .use_imm5 (use_imm5),
      .imm5     (imm5),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .count    (count),
      .full     (full),
      .busy     (busy),
      .done     (done),
      .checksum (checksum),
      .dbg_state(dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [7:0] exp_cs(input logic [7:0] x);
`ifdef LOADER_CHECKSUM_EN
      return x;
`else
      return 8'h00 & x;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_reg(input logic [2:0] op, input logic [1:0] r, input logic [2:0] l,
                            input logic last);
      in_valid = 1'b1; use_imm5 = 1'b0; op_code = op; rs = r; low3 = l;
      imm5 = 5'b11111; in_last = last;
   endtask

   task automatic drive_imm(input logic [2:0] op, input logic [4:0] im, input logic [1:0] r,
                            input logic [2:0] l, input logic last);
      in_valid = 1'b1; use_imm5 = 1'b1; op_code = op; imm5 = im; rs = r; low3 = l;
      in_last = last;
   endtask

   task automatic idle_in();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // Reset state
      #2;
      check("rst_in_ready", in_ready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_checksum", checksum, 0);
      check("rst_state", dbg_state, 0);
      #10 reset_n = 1'b1;
      tick();

      // T1: single register-form beat, 101_10_011 = B3
      do_start();
      check("t1_in_ready", in_ready, 1);
      check("t1_busy", busy, 1);
      drive_reg(3'b101, 2'b10, 3'b011, 1'b1);
      tick();
      idle_in();
      check("t1_we", mem_we, 1);
      check("t1_addr", mem_addr, 0);
      check("t1_wdata", mem_wdata, 8'hB3);
      check("t1_done", done, 1);
      check("t1_count", count, 1);
      check("t1_ready_done", in_ready, 0);
      tick();
      check("t1_idle_busy", busy, 0);
      check("t1_idle_we", mem_we, 0);
      check("t1_idle_done", done, 0);
      check("t1_idle_count", count, 1);
      check("t1_checksum", checksum, exp_cs(8'hB3));

      // T2: immediate form, 001_11111 = 3F
      do_start();
      check("t2_count_clr", count, 0);
      check("t2_cs_clr", checksum, 0);
      drive_imm(3'b001, 5'b11111, 2'b00, 3'b000, 1'b1);
      tick();
      idle_in();
      check("t2_wdata", mem_wdata, 8'h3F);
      check("t2_addr", mem_addr, 0);
      check("t2_done", done, 1);
      tick();

      // T3: 4-beat burst: EA, 45 (imm, rs/low3 ignored), 1D (imm5 ignored), 81
      do_start();
      drive_reg(3'b111, 2'b01, 3'b010, 1'b0);
      tick();
      check("t3_addr0", mem_addr, 0);
      check("t3_data0", mem_wdata, 8'hEA);
      check("t3_we0", mem_we, 1);
      drive_imm(3'b010, 5'b00101, 2'b11, 3'b111, 1'b0);
      tick();
      check("t3_addr1", mem_addr, 1);
      check("t3_data1", mem_wdata, 8'h45);
      check("t3_we1", mem_we, 1);
      drive_reg(3'b000, 2'b11, 3'b101, 1'b0);
      tick();
      check("t3_addr2", mem_addr, 2);
      check("t3_data2", mem_wdata, 8'h1D);
      check("t3_done2", done, 0);
      drive_reg(3'b100, 2'b00, 3'b001, 1'b1);
      tick();
      idle_in();
      check("t3_addr3", mem_addr, 3);
      check("t3_data3", mem_wdata, 8'h81);
      check("t3_done3", done, 1);
      check("t3_we3", mem_we, 1);
      tick();
      check("t3_count", count, 4);
      check("t3_checksum", checksum, exp_cs(8'h33));
      check("t3_busy", busy, 0);

      // T4: fill all 32 words without in_last; word i = {000, i[4:3], i[2:0]} = i
      do_start();
      for (int i = 0; i < DEPTH; i++) begin
         drive_reg(3'b000, 2'(i >> 3), 3'(i), 1'b0);
         tick();
         check("t4_we", mem_we, 1);
         check("t4_addr", mem_addr, i);
         check("t4_wdata", mem_wdata, i);
      end
      // in_valid stays high after the fill
      check("t4_full", full, 1);
      check("t4_ready", in_ready, 0);
      check("t4_done", done, 1);
      check("t4_count", count, 32);
      tick();
      check("t4_no_wrap_we", mem_we, 0);
      check("t4_full_idle", full, 1);
      check("t4_count_idle", count, 32);
      check("t4_addr_hold", mem_addr, 31);
      check("t4_checksum", checksum, exp_cs(8'h00));
      tick();
      check("t4_no_wrap_we2", mem_we, 0);
      idle_in();

      // T5: reset the cycle after an accept
      do_start();
      drive_reg(3'b110, 2'b01, 3'b001, 1'b0);
      tick();
      idle_in();
      check("t5_we_pre", mem_we, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_we_rst", mem_we, 0);
      check("t5_count_rst", count, 0);
      check("t5_addr_rst", mem_addr, 0);
      check("t5_wdata_rst", mem_wdata, 0);
      check("t5_busy_rst", busy, 0);
      check("t5_state_rst", dbg_state, 0);
      check("t5_full_rst", full, 0);
      #3 reset_n = 1'b1;
      tick();
      do_start();
      drive_reg(3'b011, 2'b01, 3'b100, 1'b1);
      tick();
      idle_in();
      check("t5_restart_addr", mem_addr, 0);
      check("t5_restart_data", mem_wdata, 8'h6C);
      tick();

      // T6: start ignored in LOAD, bubble holds write port, in_valid ignored in IDLE
      do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t6_count_start", count, 0);
      check("t6_busy", busy, 1);
      check("t6_we_none", mem_we, 0);
      drive_reg(3'b010, 2'b10, 3'b110, 1'b0);   // 010_10_110 = 56
      tick();
      idle_in();
      check("t6_data_a", mem_wdata, 8'h56);
      tick();
      check("t6_bubble_we", mem_we, 0);
      check("t6_hold_addr", mem_addr, 0);
      check("t6_hold_data", mem_wdata, 8'h56);
      drive_imm(3'b111, 5'b00001, 2'b00, 3'b000, 1'b1);   // E1
      tick();
      idle_in();
      check("t6_addr_b", mem_addr, 1);
      check("t6_data_b", mem_wdata, 8'hE1);
      check("t6_done", done, 1);
      tick();
      drive_reg(3'b101, 2'b11, 3'b111, 1'b1);
      tick();
      check("t6_idle_we", mem_we, 0);
      check("t6_idle_count", count, 2);
      check("t6_idle_busy", busy, 0);
      tick();
      check("t6_idle_we2", mem_we, 0);
      check("t6_checksum", checksum, exp_cs(8'hB7));
      idle_in();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_encoder_loader.md
# instruction_encoder_loader

Packs instruction fields (OPCode, Rs, low bits or a 5-bit immediate) into 8-bit instruction words and writes them sequentially into the instruction memory. This block is the inverse of the instruction-word field split used on the fetch side: `word = {OPCode[2:0], Rs[1:0], low3[2:0]}` or `word = {OPCode[2:0], imm5[4:0]}`. It sits between the test/boot program source and the instruction memory write port and loads a program before the processor runs.

## Interface
- `DEPTH`, default 32: number of instruction memory words. Must be a power of two, ≥2.
- `ADDR_W`, default 5: address width, `$clog2(DEPTH)`.

- `clock`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to begin a load session. Honoured only in IDLE.
- `in_valid`  in  1: field set valid.
- `in_ready`  out  1: block can accept a field set.
- `in_last`  in  1: qualifies the final field set of the program.
- `op_code`  in  3: OPCode field, word bits [7:5].
- `rs`  in  2: Rs field, word bits [4:3] when `use_imm5=0`.
- `low3`  in  3: word bits [2:0] when `use_imm5=0`.
- `use_imm5`  in  1: 1 selects `imm5` for word bits [4:0].
- `imm5`  in  5: immediate field, word bits [4:0] when `use_imm5=1`.
- `mem_we`  out  1: instruction memory write enable.
- `mem_addr`  out  ADDR_W: write address.
- `mem_wdata`  out  8: packed instruction word.
- `count`  out  ADDR_W+1: words accepted in the current or last session.
- `full`  out  1: `count == DEPTH`.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse at session end.
- `checksum`  out  8: XOR of all words written this session (see Configuration).

## Operation
- States: IDLE, LOAD, DONE.
- **IDLE**:
  - `start=1` clears `count` and `checksum` to 0 and moves to LOAD.
  - `in_valid` is ignored.
- **LOAD**:
  - `in_ready = !full`. A beat is accepted when `in_valid && in_ready`.
  - On accept, the word is packed and registered into the write stage. `count` increments by 1.
  - Moves to DONE on an accepted beat with `in_last=1`, or on an accepted beat that makes `count == DEPTH`.
- **DONE**:
  - `done=1` and `in_ready=0` for exactly one cycle, then return to IDLE.
- `start` outside IDLE is ignored.
- `count`, `checksum` and `full` hold their values in IDLE until the next `start`.
- The address wraps only by a session restart. No write occurs past `DEPTH-1`. While `full=1`, `in_ready` stays 0.
- Fields are used verbatim. With `use_imm5=1`, `rs` and `low3` are ignored; with `use_imm5=0`, `imm5` is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `count`, `full`, `busy`, `done`, `checksum` all 0.
- Write latency is 1 cycle: a beat accepted at edge N drives `mem_we=1` in cycle N+1, with `mem_addr = count` before increment and the packed word.
- Throughput is one word per cycle with `in_valid` held high.
- The last beat's write cycle coincides with the DONE cycle, so `done` and the final `mem_we` are asserted together.
- `mem_we` deasserts the cycle after a non-accept. `mem_addr` and `mem_wdata` hold their last values.
- `reset_n` low mid-session: immediate return to reset values. Any pending write is dropped (`mem_we=0` immediately).

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `checksum` XOR-accumulates each word on its `mem_we` cycle.
  - It is cleared by `start` and reset.
- Undefined:
  - `checksum` is tied to 8'h00 and no accumulator register exists.

## Test plan
- Reset, then `start`, then one beat `op_code=3'b101, rs=2'b10, low3=3'b011, use_imm5=0, in_last=1` -> next cycle `mem_we=1, mem_addr=0, mem_wdata=8'hB3, done=1`; `count=1`; then IDLE with `busy=0`.
- Immediate packing: `op_code=3'b001, imm5=5'b11111, use_imm5=1`, with `rs=2'b00, low3=3'b000` -> `mem_wdata=8'h3F`.
- Back-to-back burst of 4 beats with `in_valid` held high, last beat flagged -> `mem_addr` 0,1,2,3 on consecutive cycles; `count=4`; `checksum` equals the XOR of the 4 words (0 without `LOADER_CHECKSUM_EN`).
- Fill to DEPTH=32 without `in_last` -> after the 32nd accept, `full=1`, `in_ready=0`, `done` pulses, and there is no write to address 32 or any wrap write to 0.
- `reset_n` asserted low the cycle after an accept -> `mem_we=0` immediately, all outputs 0, state IDLE. `start` after reset restarts at `mem_addr=0`.
- `start` pulsed during LOAD and `in_valid` driven during IDLE -> both ignored: `count` unchanged, no `mem_we`.
